i2s_rx_feeder: RTL and testbench

I2S_RX_FEEDER -- requirements
Module: i2s_rx_feeder

---
 rtl/audiodac_pkg.sv | 9 +
 rtl/sync_ff.sv | 21 ++
 rtl/i2s_rx_feeder.sv | 109 ++++++++++
 tb/tb_i2s_rx_feeder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/audiodac_pkg.sv
// audiodac_pkg: shared constants for the audio DAC feed path.
//   SYNC_STAGES_DEF : default synchroniser depth for asynchronous inputs
//   ST_*            : handshake FSM state encoding
package audiodac_pkg;
    localparam int SYNC_STAGES_DEF = 2;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchroniser for a single asynchronous bit.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, clears the chain
//   d     : asynchronous input
//   q     : synchronised output
module sync_ff
    import audiodac_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) chain <= '0;
        else       chain <= {chain[STAGES-2:0], d};
    assign q = chain[STAGES-1];
endmodule

// File: rtl/i2s_rx_feeder.sv
// i2s_rx_feeder: I2S receiver forwarding one slot to a FIFO over a 4-phase handshake.
//   clk_i, rst_i   : system clock, asynchronous active-high reset
//   i2s_sck_i      : I2S bit clock (asynchronous, oversampled by clk_i)
//   i2s_ws_i       : word select, 0 = left, 1 = right
//   i2s_sd_i       : serial data, MSB first
//   chan_sel_i     : slot to forward, 0 = left, 1 = right
//   en_i           : capture enable
//   fifo_o         : word offered downstream
//   fifo_rdy_o     : request, held until fifo_ack_i rises
//   fifo_ack_i     : downstream acknowledge (asynchronous)
//   overrun_o      : sticky flag, a captured word was dropped
//   clr_overrun_i  : clears overrun_o
module i2s_rx_feeder
    import audiodac_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i2s_sck_i,
    input  logic              i2s_ws_i,
    input  logic              i2s_sd_i,
    input  logic              chan_sel_i,
    input  logic              en_i,
    output logic [DATA_W-1:0] fifo_o,
    output logic              fifo_rdy_o,
    input  logic              fifo_ack_i,
    output logic              overrun_o,
    input  logic              clr_overrun_i
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic              sck_s, ws_s, sd_s, ack_s;
    logic              sck_prev, ws_prev, slot_ok, pending;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] sh, hold, cap;
    logic [1:0]        state;
    logic              sck_rise, ws_chg, word_ev, take;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sck (.clk_i(clk_i), .rst_i(rst_i), .d(i2s_sck_i),  .q(sck_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_ws  (.clk_i(clk_i), .rst_i(rst_i), .d(i2s_ws_i),   .q(ws_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_sd  (.clk_i(clk_i), .rst_i(rst_i), .d(i2s_sd_i),   .q(sd_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_ack (.clk_i(clk_i), .rst_i(rst_i), .d(fifo_ack_i), .q(ack_s));

    assign sck_rise = sck_s & ~sck_prev;
    assign ws_chg   = sck_rise & (ws_s != ws_prev);
    // The bit sampled on the ws-change edge is still the last bit of the ending
    // slot (one-bit delay), so it is merged into the captured word here.
    assign cap      = (cnt < FULL) ? (sh | ({{(DATA_W-1){1'b0}}, sd_s} << (LAST - cnt))) : sh;
    // slot_ok rejects the partial slot seen after reset until a real boundary.
    assign word_ev  = ws_chg & slot_ok & en_i & (ws_prev == chan_sel_i);
    assign take     = (state == ST_IDLE) & pending;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_prev <= 1'b0;
            ws_prev  <= 1'b0;
            slot_ok  <= 1'b0;
            cnt      <= '0;
            sh       <= '0;
        end else begin
            sck_prev <= sck_s;
            if (sck_rise) begin
                ws_prev <= ws_s;
                if (ws_s != ws_prev) begin
                    cnt     <= '0;
                    sh      <= '0;
                    slot_ok <= 1'b1;
                end else if (cnt < FULL) begin
                    sh  <= cap;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // A word landing in the same cycle the FSM takes the old one is not a drop:
    // fifo_o gets the old hold value while hold is refilled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            fifo_o     <= '0;
            fifo_rdy_o <= 1'b0;
            pending    <= 1'b0;
            hold       <= '0;
            overrun_o  <= 1'b0;
        end else begin
            if (word_ev) hold <= cap;
            pending   <= word_ev | (pending & ~take);
            overrun_o <= (word_ev & pending & ~take) | (overrun_o & ~clr_overrun_i);
            case (state)
                ST_IDLE: if (pending) begin
                    fifo_o     <= hold;
                    fifo_rdy_o <= 1'b1;
                    state      <= ST_REQ;
                end
                ST_REQ: if (ack_s) begin
                    fifo_rdy_o <= 1'b0;
                    state      <= ST_RELEASE;
                end
                ST_RELEASE: if (!ack_s) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2s_rx_feeder.sv
// tb_i2s_rx_feeder: directed bench for i2s_rx_feeder with an I2S stream driver and FIFO responder.
module tb_i2s_rx_feeder;
    logic        clk = 1'b0, rst = 1'b1;
    logic        sck = 1'b0, ws = 1'b0, sd = 1'b0;
    logic        sel = 1'b0, en = 1'b1, clr = 1'b0;
    logic        next_sel = 1'b0, next_en = 1'b1, last_bit = 1'b0;
    logic        auto_ack = 1'b1, ack_auto = 1'b0, ack_man = 1'b0, fifo_ack;
    logic        rdy, ov, rdy_q = 1'b0;
    logic [15:0] fifo;
    logic [15:0] words [0:31];
    int          tests = 0, fails = 0, nw = 0, rises = 0, dly = 0, nw0 = 0, r0 = 0;

    assign fifo_ack = auto_ack ? ack_auto : ack_man;

    i2s_rx_feeder dut (
        .clk_i(clk), .rst_i(rst), .i2s_sck_i(sck), .i2s_ws_i(ws), .i2s_sd_i(sd),
        .chan_sel_i(sel), .en_i(en), .fifo_o(fifo), .fifo_rdy_o(rdy),
        .fifo_ack_i(fifo_ack), .overrun_o(ov), .clr_overrun_i(clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rdy && !rdy_q) rises++;
        rdy_q = rdy;
        if (auto_ack && rdy && !ack_auto) begin
            if (dly == 2) begin
                ack_auto = 1'b1;
                if (nw < 32) words[nw] = fifo;
                nw++;
                dly = 0;
            end else dly++;
        end else if (!rdy && ack_auto) ack_auto = 1'b0;
        else dly = 0;
    end

    task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task wait_rdy(input logic v, input string tag);
        int k = 0;
        while (rdy !== v && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'd0, rdy}, {31'd0, v});
    endtask

    // One sck period per bit; data lags ws by one period as in standard I2S.
    task send_slot(input logic w, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            if (i == 4) begin
                sel = next_sel;
                en  = next_en;
            end
            sck = 1'b0; ws = w; sd = last_bit;
            last_bit = d[31-i];
            #40; sck = 1'b1; #40;
        end
    endtask

    initial begin
        wait_clk(3);
        check("rst_rdy", {31'd0, rdy}, 32'd0);
        check("rst_fifo", {16'd0, fifo}, 32'd0);
        check("rst_ov", {31'd0, ov}, 32'd0);
        rst = 1'b0;
        wait_clk(3);

        send_slot(1'b1, 32'd0, 4);
        send_slot(1'b0, 32'h1234_0000, 32);
        send_slot(1'b1, 32'h5678_0000, 32);
        wait_clk(40);
        check("a_count", nw, 1);
        check("a_word", {16'd0, words[0]}, 32'h1234);
        check("a_rises", rises, 1);
        check("a_rdy_low", {31'd0, rdy}, 32'd0);

        next_sel = 1'b1;
        send_slot(1'b0, 32'h1234_0000, 32);
        send_slot(1'b1, 32'h5678_0000, 32);
        next_sel = 1'b0;
        send_slot(1'b0, 32'hA500_0000, 8);
        send_slot(1'b1, 32'h0000_0000, 8);
        send_slot(1'b0, 32'hABCD_EF00, 24);
        send_slot(1'b1, 32'h0000_0000, 8);
        wait_clk(40);
        check("bc_count", nw, 4);
        check("b_right", {16'd0, words[1]}, 32'h5678);
        check("c_short8", {16'd0, words[2]}, 32'hA500);
        check("c_long24", {16'd0, words[3]}, 32'hABCD);

        auto_ack = 1'b0;
        send_slot(1'b0, 32'h1111_0000, 16);
        send_slot(1'b1, 32'h0, 4);
        send_slot(1'b0, 32'h2222_0000, 16);
        send_slot(1'b1, 32'h0, 4);
        send_slot(1'b0, 32'h3333_0000, 16);
        send_slot(1'b1, 32'h0, 4);
        wait_clk(20);
        check("d_rdy_held", {31'd0, rdy}, 32'd1);
        check("d_first", {16'd0, fifo}, 32'h1111);
        check("d_overrun", {31'd0, ov}, 32'd1);
        ack_man = 1'b1;
        wait_rdy(1'b0, "d_rdy_drop");
        ack_man = 1'b0;
        wait_rdy(1'b1, "d_rdy_again");
        check("d_latest", {16'd0, fifo}, 32'h3333);
        ack_man = 1'b1;
        wait_rdy(1'b0, "d_rdy_drop2");
        ack_man = 1'b0;
        wait_clk(10);
        check("d_ov_kept", {31'd0, ov}, 32'd1);
        clr = 1'b1;
        wait_clk(1);
        clr = 1'b0;
        wait_clk(1);
        check("d_ov_clr", {31'd0, ov}, 32'd0);

        send_slot(1'b0, 32'h4444_0000, 16);
        send_slot(1'b1, 32'h0, 4);
        wait_rdy(1'b1, "e_rdy_up");
        check("e_word", {16'd0, fifo}, 32'h4444);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("e_rst_rdy", {31'd0, rdy}, 32'd0);
        check("e_rst_fifo", {16'd0, fifo}, 32'd0);
        check("e_rst_ov", {31'd0, ov}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        auto_ack = 1'b1;
        wait_clk(3);
        nw0 = nw;
        send_slot(1'b1, 32'h0, 4);
        send_slot(1'b0, 32'h7777_0000, 32);
        send_slot(1'b1, 32'h0, 4);
        wait_clk(40);
        check("e_count", nw, nw0 + 1);
        check("e_after_rst", {16'd0, words[nw0]}, 32'h7777);

        nw0 = nw;
        r0 = rises;
        next_en = 1'b0;
        send_slot(1'b1, 32'h0, 8);
        send_slot(1'b0, 32'h1234_0000, 32);
        send_slot(1'b1, 32'h0, 32);
        send_slot(1'b0, 32'h1234_0000, 32);
        next_en = 1'b1;
        send_slot(1'b1, 32'h0, 32);
        wait_clk(20);
        check("f_no_words", nw, nw0);
        check("f_no_rdy", rises, r0);
        send_slot(1'b0, 32'h2468_0000, 16);
        send_slot(1'b1, 32'h0, 4);
        wait_clk(40);
        check("f_count", nw, nw0 + 1);
        check("f_reenable", {16'd0, words[nw0]}, 32'h2468);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
